nibble_stream_encryptor: RTL and testbench

- Upstream stage of the 4-bit decryption circuit; produces the ciphertext nibble that drives its P,Q,R,S inputs.
- Accepts plaintext nibbles over a valid/ready handshake.
- Encrypts each nibble with a rolling key from a 4-bit LFSR, tags frame boundaries, and buffers results in a 2-entry output FIFO.

---
 rtl/enc_pkg.sv | 32 +++
 rtl/nibble_fifo2.sv | 66 ++++++
 rtl/nibble_stream_encryptor.sv | 90 +++++++++
 tb/tb_nibble_stream_encryptor.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the nibble encryptor and its companion decryptor.
// Holds the nibble type, the FIFO entry layout, the default LFSR seed and
// the small key/cipher helper functions that both sides of the link use so
// their reference behaviour stays identical.
package enc_pkg;

  typedef logic [3:0] nibble_t;

  // One FIFO entry: frame-end tag plus the ciphertext nibble.
  typedef struct packed {
    logic    last;
    nibble_t data;
  } entry_t;

  localparam nibble_t SEED_DEFAULT = 4'b1001;

  // One step of the rolling-key LFSR (shift left, feedback from bits 3 and 2).
  function automatic nibble_t lfsr_next(input nibble_t k);
    return {k[2:0], k[3] ^ k[2]};
  endfunction

  // Rotate a nibble left by one position.
  function automatic nibble_t rotl1(input nibble_t n);
    return {n[2:0], n[3]};
  endfunction

  // An all-zero LFSR state would lock up, so zero is mapped to 0001.
  function automatic nibble_t fix_zero(input nibble_t n);
    return (n == 4'b0000) ? 4'b0001 : n;
  endfunction

endpackage

// File: rtl/nibble_fifo2.sv
// Two-entry valid/ready FIFO of {last, data} entries.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   push_i          - write push_entry_i this cycle (ignored when full)
//   push_entry_i    - entry to store
//   push_ready_o    - a slot is free (depends only on registered count)
//   pop_valid_o     - head_o holds a valid entry
//   pop_ready_i     - consumer takes the head entry (ignored when empty)
//   head_o          - oldest stored entry; holds its last value when empty
module nibble_fifo2
  import enc_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_i,
  input  entry_t push_entry_i,
  output logic   push_ready_o,
  output logic   pop_valid_o,
  input  logic   pop_ready_i,
  output entry_t head_o
);

  entry_t     mem_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  // Guarding push/pop here keeps the count inside 0..2 even if a caller
  // ignores the ready/valid flags.
  assign push = push_i && (count_q != 2'd2);
  assign pop  = pop_ready_i && (count_q != 2'd0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= push_entry_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign push_ready_o = (count_q != 2'd2);
  assign pop_valid_o  = (count_q != 2'd0);
  assign head_o       = mem_q[rd_ptr_q];

endmodule

// File: rtl/nibble_stream_encryptor.sv
// Encrypts a stream of plaintext nibbles with a rolling LFSR key, tags the
// last nibble of each frame and buffers the ciphertext in a 2-entry FIFO
// feeding the 4-bit decryptor (out_data MSB = P ... LSB = S).
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_data/in_valid    - plaintext nibble and its valid flag
//   in_ready            - a nibble can be accepted this cycle
//   key_load/key_val    - pulse: load key_val as key and restart the frame
//   out_data/out_last   - head ciphertext nibble and its frame-end tag
//   out_valid/out_ready - output handshake
module nibble_stream_encryptor
  import enc_pkg::*;
#(
  parameter nibble_t     SEED      = SEED_DEFAULT,
  parameter int unsigned FRAME_LEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       key_load,
  input  logic [3:0] key_val,
  output logic [3:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last
);

  localparam nibble_t    SEED_SAFE = fix_zero(SEED);
  localparam logic [3:0] LAST_CNT  = 4'(FRAME_LEN - 1);

  nibble_t    key_q, key_d;
  logic [3:0] frame_cnt_q, frame_cnt_d;
  logic       accept;
  logic       is_last;
  entry_t     push_entry;
  entry_t     head;

  assign accept  = in_valid && in_ready;
  assign is_last = (frame_cnt_q == LAST_CNT);

  // The pushed entry always uses the key and count from before this edge,
  // even when key_load arrives in the same cycle.
  assign push_entry.data = rotl1(in_data) ^ key_q;
  assign push_entry.last = is_last;

  // key_load wins over both the LFSR step and the frame-end reseed.
  always_comb begin
    key_d       = key_q;
    frame_cnt_d = frame_cnt_q;
    if (key_load) begin
      key_d       = fix_zero(key_val);
      frame_cnt_d = 4'd0;
    end else if (accept) begin
      if (is_last) begin
        key_d       = SEED_SAFE;
        frame_cnt_d = 4'd0;
      end else begin
        key_d       = lfsr_next(key_q);
        frame_cnt_d = frame_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q       <= SEED_SAFE;
      frame_cnt_q <= 4'd0;
    end else begin
      key_q       <= key_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  nibble_fifo2 u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (accept),
    .push_entry_i (push_entry),
    .push_ready_o (in_ready),
    .pop_valid_o  (out_valid),
    .pop_ready_i  (out_ready),
    .head_o       (head)
  );

  assign out_data = head.data;
  assign out_last = head.last;

endmodule

// File: tb/tb_nibble_stream_encryptor.sv
// Self-checking bench for nibble_stream_encryptor: directed scenarios with
// literal expected values, followed by a randomized run checked against a
// queue-based reference model built from plain arithmetic.
module tb_nibble_stream_encryptor;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       key_load;
  logic [3:0] key_val;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  int checks;
  int errors;

  // Reference model state
  int         modelKey;
  int         modelCnt;
  logic [4:0] modelQ[$];

  localparam int REF_SEED  = 9;
  localparam int REF_FRAME = 8;

  nibble_stream_encryptor #(.SEED(4'b1001), .FRAME_LEN(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key_load  (key_load),
    .key_val   (key_val),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Next key as an integer: double, drop the carry, bring in bit3 xor bit2.
  function automatic int refStep(input int k);
    return ((k * 2) % 16) + (((k / 8) + (k / 4)) % 2);
  endfunction

  // Rotate the plaintext left by one and xor with the key.
  function automatic int refCipher(input int d, input int k);
    return (((d * 2) % 16) + (d / 8)) ^ k;
  endfunction

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %b expected %b", tag, observed, expected);
    end
  endtask

  // Checks the head entry at the current time against literal values.
  task automatic checkHead(input string tag, input logic [3:0] expData, input logic expLast);
    checkOutput({tag, "_valid"}, {3'b0, out_valid}, 4'b0001);
    checkOutput({tag, "_data"}, out_data, expData);
    checkOutput({tag, "_last"}, {3'b0, out_last}, {3'b0, expLast});
  endtask

  // Drives one cycle of inputs, checks the DUT against the model before the
  // edge, then advances the model across the edge.
  task automatic applyStimulus(input logic vld, input logic [3:0] d, input logic ordy,
                               input logic kl, input logic [3:0] kv);
    bit pushing, popping, isLast;
    int c;
    in_valid  = vld;
    in_data   = d;
    out_ready = ordy;
    key_load  = kl;
    key_val   = kv;
    @(negedge clk);
    checkOutput("in_ready", {3'b0, in_ready}, (modelQ.size() < 2) ? 4'b0001 : 4'b0000);
    checkOutput("out_valid", {3'b0, out_valid}, (modelQ.size() > 0) ? 4'b0001 : 4'b0000);
    if (modelQ.size() > 0) begin
      checkOutput("model_data", out_data, modelQ[0][3:0]);
      checkOutput("model_last", {3'b0, out_last}, {3'b0, modelQ[0][4]});
    end
    pushing = vld && (modelQ.size() < 2);
    popping = ordy && (modelQ.size() > 0);
    if (popping) void'(modelQ.pop_front());
    if (pushing) begin
      isLast = (modelCnt == REF_FRAME - 1);
      c = refCipher(int'(d), modelKey);
      modelQ.push_back({isLast, 4'(c)});
      if (isLast) begin
        modelKey = REF_SEED;
        modelCnt = 0;
      end else begin
        modelKey = refStep(modelKey);
        modelCnt = modelCnt + 1;
      end
    end
    if (kl) begin
      modelKey = (kv == 4'd0) ? 1 : int'(kv);
      modelCnt = 0;
    end
    @(posedge clk);
    #1;
    key_load = 1'b0;
    in_valid = 1'b0;
  endtask

  // Asserts reset between clock edges and checks the outputs clear at once.
  task automatic doReset();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", {3'b0, out_valid}, 4'b0000);
    checkOutput("rst_in_ready", {3'b0, in_ready}, 4'b0001);
    checkOutput("rst_out_data", out_data, 4'b0000);
    checkOutput("rst_out_last", {3'b0, out_last}, 4'b0000);
    modelQ.delete();
    modelKey = REF_SEED;
    modelCnt = 0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] frameExp [8];

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b1;
    in_data   = 4'd0;
    in_valid  = 1'b0;
    key_load  = 1'b0;
    key_val   = 4'd0;
    out_ready = 1'b0;
    modelKey  = REF_SEED;
    modelCnt  = 0;
    frameExp  = '{4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0111};
    @(posedge clk);
    #1;

    // Reset state and first cipher
    doReset();
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 4'd0);
    checkHead("first_cipher", 4'b1001, 1'b0);

    // Second nibble uses the rolled key 0011
    applyStimulus(1'b1, 4'b1000, 1'b1, 1'b0, 4'd0);
    checkHead("key_roll", 4'b0010, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 4'd0);

    // Full frame of zeros, then reseeded ninth nibble
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0, 4'd0);
      checkHead("frame", frameExp[i], (i == 7));
    end
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0, 4'd0);
    checkHead("reseed", 4'b1001, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 4'd0);

    // Backpressure
    doReset();
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 4'd0);
    checkOutput("bp_in_ready_low", {3'b0, in_ready}, 4'b0000);
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 4'd0);
    checkHead("bp_stall", 4'b1001, 1'b0);
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0, 4'd0);
    checkOutput("bp_in_ready_high", {3'b0, in_ready}, 4'b0001);
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 4'd0);
    checkHead("bp_third", 4'b0110, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 4'd0);

    // key_load colliding with an accept at frame count 3
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0, 4'd0);
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b1, 4'b0000);
    checkHead("kl_collide", 4'b1101, 1'b0);
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0, 4'd0);
    checkHead("kl_newkey", 4'b0001, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0, 4'd0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 4'd0);

    // Asynchronous reset with a full FIFO
    doReset();
    applyStimulus(1'b1, 4'b0101, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b1, 4'b1110, 1'b0, 1'b0, 4'd0);
    checkOutput("full_before_reset", {3'b0, in_ready}, 4'b0000);
    doReset();
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 4'd0);
    checkHead("after_reset", 4'b1001, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 4'd0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0,
                    4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
